// File: rtl/br_pred_unit_if.sv
// Fetch-lookup, prediction, branch-resolution and flush signals of the branch predictor.
interface br_pred_unit_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_vld;
  logic [ADDR_W-1:0] instr;
  logic [ADDR_W-1:0] pc;
  logic              pred_vld;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_pc;
  logic              upd_vld;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic              upd_pred;
  logic [ADDR_W-1:0] upd_tgt;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;

  modport master (
    output fetch_vld, instr, pc, upd_vld, upd_pc, upd_taken, upd_pred, upd_tgt,
    input  pred_vld, pred_taken, pred_pc, flush, flush_pc
  );

  modport slave (
    input  fetch_vld, instr, pc, upd_vld, upd_pc, upd_taken, upd_pred, upd_tgt,
    output pred_vld, pred_taken, pred_pc, flush, flush_pc
  );
endinterface

// File: rtl/br_pred_unit.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, registered outputs.
// Define BR_PRED_BYPASS_EN to forward a same-cycle update to a same-index lookup.
module br_pred_unit #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 9,
  parameter int DEPTH  = 8
) (
  input logic          clk,
  input logic          rst,
  br_pred_unit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] OP_BRANCH = 4'b1100;

  logic [1:0]        bht [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        ctr_next;
  logic [1:0]        ctr_rd;
  logic              is_branch;
  logic [ADDR_W-1:0] br_pc;
  logic              taken_nxt;

  assign rd_idx    = bus.pc[IDX_W-1:0];
  assign wr_idx    = bus.upd_pc[IDX_W-1:0];
  assign is_branch = bus.instr[ADDR_W-1:ADDR_W-4] == OP_BRANCH;
  assign br_pc     = bus.pc + {{(ADDR_W-OFF_W){bus.instr[OFF_W-1]}}, bus.instr[OFF_W-1:0]};

  always_comb begin
    ctr_next = bht[wr_idx];
    if (bus.upd_taken) begin
      if (bht[wr_idx] != 2'b11) ctr_next = bht[wr_idx] + 2'b01;
    end else begin
      if (bht[wr_idx] != 2'b00) ctr_next = bht[wr_idx] - 2'b01;
    end
  end

  always_comb begin
    ctr_rd = bht[rd_idx];
`ifdef BR_PRED_BYPASS_EN
    if (bus.upd_vld && (wr_idx == rd_idx)) ctr_rd = ctr_next;
`endif
  end

  assign taken_nxt = bus.fetch_vld & is_branch & ctr_rd[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= 2'b01;
    end else if (bus.upd_vld) begin
      bht[wr_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pred_vld   <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_pc    <= '0;
      bus.flush      <= 1'b0;
      bus.flush_pc   <= '0;
    end else begin
      bus.pred_vld   <= bus.fetch_vld;
      bus.pred_taken <= taken_nxt;
      bus.pred_pc    <= taken_nxt ? br_pc : bus.pc;
      bus.flush      <= bus.upd_vld & (bus.upd_taken != bus.upd_pred);
      // Redirect target tracks the EX inputs every cycle; it is only meaningful with flush.
      bus.flush_pc   <= bus.upd_taken ? bus.upd_tgt : bus.upd_pc;
    end
  end
endmodule

// File: tb/tb_br_pred_unit.sv
// Self-checking bench for br_pred_unit: vector table plus hand sequences, scoreboard queue.
module tb_br_pred_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  br_pred_unit_if #(.ADDR_W(16)) bus ();

  br_pred_unit #(.ADDR_W(16), .OFF_W(9), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        fv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic        up;
    logic [15:0] utgt;
    logic        pv;
    logic        pt;
    logic [15:0] ppc;
    logic        fl;
    logic [15:0] fpc;
  } vec_t;

  typedef struct packed {
    logic        pv;
    logic        pt;
    logic [15:0] ppc;
    logic        fl;
    logic [15:0] fpc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];

`ifdef BR_PRED_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " pred_vld"},   {15'd0, bus.pred_vld},   {15'd0, e.pv});
      chk({tag, " pred_taken"}, {15'd0, bus.pred_taken}, {15'd0, e.pt});
      chk({tag, " pred_pc"},    bus.pred_pc,             e.ppc);
      chk({tag, " flush"},      {15'd0, bus.flush},      {15'd0, e.fl});
      if (e.fl) chk({tag, " flush_pc"}, bus.flush_pc, e.fpc);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    bus.fetch_vld = v.fv;
    bus.instr     = v.instr;
    bus.pc        = v.pc;
    bus.upd_vld   = v.uv;
    bus.upd_pc    = v.upc;
    bus.upd_taken = v.ut;
    bus.upd_pred  = v.up;
    bus.upd_tgt   = v.utgt;
    sb.push_back('{pv: v.pv, pt: v.pt, ppc: v.ppc, fl: v.fl, fpc: v.fpc});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  function automatic vec_t upd(input logic [15:0] upc, input logic ut, input logic up,
                               input logic [15:0] utgt);
    vec_t v;
    v = '{fv: 1'b0, instr: 16'h0000, pc: 16'h0000, uv: 1'b1, upc: upc, ut: ut, up: up,
          utgt: utgt, pv: 1'b0, pt: 1'b0, ppc: 16'h0000, fl: (ut != up),
          fpc: ut ? utgt : upc};
    return v;
  endfunction

  function automatic vec_t look(input logic [15:0] instr, input logic [15:0] pc,
                                input logic pt, input logic [15:0] ppc);
    vec_t v;
    v = '{fv: 1'b1, instr: instr, pc: pc, uv: 1'b0, upc: 16'h0000, ut: 1'b0, up: 1'b0,
          utgt: 16'h0000, pv: 1'b1, pt: pt, ppc: ppc, fl: 1'b0, fpc: 16'h0000};
    return v;
  endfunction

  initial begin
    vec_t v;
    bus.fetch_vld = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.upd_vld   = 1'b0;
    bus.upd_pc    = '0;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    bus.upd_tgt   = '0;

    //               fv  instr     pc        uv  upc       ut  up  utgt      pv  pt  ppc       fl  fpc
    tbl[0]  = '{1'b1, 16'hC005, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0015, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0015};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0015, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 16'hC005, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0015, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 16'h1005, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000};
    tbl[5]  = '{1'b1, 16'hC1FF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0021, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0021};
    tbl[9]  = '{1'b1, 16'hC010, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0009, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 16'hC008, 16'h000B, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0013, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 16'hC004, 16'h000A, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h000A, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 16'hC004, 16'h000A, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h000A, 1'b0, 16'h0000};
    tbl[13] = '{1'b1, 16'hC0FF, 16'h000D, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h010C, 1'b0, 16'h0000};

    #12;
    chk("reset pred_vld",   {15'd0, bus.pred_vld},   16'h0000);
    chk("reset pred_taken", {15'd0, bus.pred_taken}, 16'h0000);
    chk("reset pred_pc",    bus.pred_pc,             16'h0000);
    chk("reset flush",      {15'd0, bus.flush},      16'h0000);
    chk("reset flush_pc",   bus.flush_pc,            16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Saturation at idx 6: four taken, one not-taken must still predict taken.
    for (int i = 0; i < 4; i++) apply(upd(16'h0006, 1'b1, 1'b1, 16'h0000), "sat_up");
    apply(upd(16'h0006, 1'b0, 1'b1, 16'h0000), "sat_dn1");
    apply(look(16'hC002, 16'h0006, 1'b1, 16'h0008), "sat_hi_look");
    for (int i = 0; i < 3; i++) apply(upd(16'h0006, 1'b0, 1'b0, 16'h0000), "sat_dn");
    apply(look(16'hC002, 16'h0006, 1'b0, 16'h0006), "sat_lo_look");
    for (int i = 0; i < 2; i++) apply(upd(16'h0006, 1'b1, 1'b1, 16'h0000), "sat_re_up");
    apply(look(16'hC002, 16'h0006, 1'b1, 16'h0008), "sat_re_look");

    // Same-index lookup and taken update from counter 1 at idx 4.
    v = look(16'hC003, 16'h0004, BYP, BYP ? 16'h0007 : 16'h0004);
    v.uv = 1'b1; v.upc = 16'h0004; v.ut = 1'b1; v.up = 1'b0; v.utgt = 16'h0077;
    v.fl = 1'b1; v.fpc = 16'h0077;
    apply(v, "bypass");
    apply(look(16'hC003, 16'h0004, 1'b1, 16'h0007), "post_upd_look");

    // Mid-stream reset: outputs clear asynchronously and counters return to 01.
    v = look(16'hC005, 16'h0010, 1'b1, 16'h0015);
    v.uv = 1'b1; v.upc = 16'h0010; v.ut = 1'b1; v.up = 1'b0; v.utgt = 16'h0055;
    v.fl = 1'b1; v.fpc = 16'h0055;
    apply(v, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("midrst pred_vld",   {15'd0, bus.pred_vld},   16'h0000);
    chk("midrst pred_taken", {15'd0, bus.pred_taken}, 16'h0000);
    chk("midrst pred_pc",    bus.pred_pc,             16'h0000);
    chk("midrst flush",      {15'd0, bus.flush},      16'h0000);
    chk("midrst flush_pc",   bus.flush_pc,            16'h0000);
    sb.delete();
    bus.fetch_vld = 1'b0;
    bus.upd_vld   = 1'b0;
    #1;
    rst = 1'b0;
    v = look(16'hC005, 16'h0010, 1'b0, 16'h0010);
    v.fv = 1'b0; v.pv = 1'b0;
    apply(v, "post_rst_idle");
    apply(look(16'hC005, 16'h0010, 1'b0, 16'h0010), "post_rst_look");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
